// File: rtl/instr_mem_pkg.sv
// Shared types and geometry for the instruction-memory block responder.
package instr_mem_pkg;

  // Responder state; encodings are fixed so waveforms match the cache-side docs.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_BITS  = 128;
  localparam int NUM_BLOCKS  = 64;
  localparam int ADDR_BITS   = 6;

endpackage

// File: rtl/instr_mem_delay_counter.sv
// Loadable down-counter that paces the fill latency; zero flags the last wait cycle.
module instr_mem_delay_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/instr_mem_block_responder.sv
// Instruction-memory responder: serves one 128-bit block per READ after
// READ_LATENCY cycles using the READ/BUSYWAIT handshake.
// Optional: define INSTMEM_READCNT_EN to add the saturating READ_COUNT output.
// The byte array is not touched by reset; the program image is placed into
// it by the surrounding environment before the first request.
module instr_mem_block_responder
  import instr_mem_pkg::*;
#(
  parameter int READ_LATENCY = 40,
  parameter     INIT_FILE    = "instr_mem.mem"
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic [ADDR_BITS-1:0]  ADDRESS,
  output logic [BLOCK_BITS-1:0] READDATA,
  output logic                  BUSYWAIT
`ifdef INSTMEM_READCNT_EN
  ,
  output logic [15:0]           READ_COUNT
`endif
);

  localparam int CNT_W     = $clog2(READ_LATENCY);
  localparam int OFF_W     = $clog2(BLOCK_BYTES);
  localparam int MEM_BYTES = NUM_BLOCKS * BLOCK_BYTES;

  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    blk_q, blk_d;
  logic [BLOCK_BITS-1:0]   rdata_q, rdata_d;
  logic [BLOCK_BITS-1:0]   blk_data;
  logic                    cnt_load, cnt_en, cnt_zero, fill_done;

  instr_mem_delay_counter #(.W(CNT_W)) u_delay (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CNT_W'(READ_LATENCY - 2)),
    .zero     (cnt_zero)
  );

  // Gather the latched block, lowest byte address into the lowest bits.
  always_comb begin
    blk_data = '0;
    for (int i = 0; i < BLOCK_BYTES; i++)
      blk_data[i*8 +: 8] = mem[{blk_q, OFF_W'(i)}];
  end

  // Handshake state machine: accept, wait out the latency, present for one cycle.
  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    rdata_d   = rdata_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      IDLE: if (READ) begin
        state_d  = BUSY;
        blk_d    = ADDRESS;
        cnt_load = 1'b1;
      end
      BUSY: begin
        if (!READ) begin
          state_d = IDLE;            // cache withdrew: drop the fill, keep old data
        end else if (cnt_zero) begin
          state_d   = DONE;
          rdata_d   = blk_data;
          fill_done = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched block address and output data registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      blk_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall rises in the same cycle READ does, so the cache never samples stale data.
  assign BUSYWAIT = (state_q == IDLE && READ) || (state_q == BUSY);
  assign READDATA = rdata_q;

`ifdef INSTMEM_READCNT_EN
  logic [15:0] rcnt_q, rcnt_d;

  // Completed fills only; stops at all-ones instead of wrapping.
  always_comb begin
    rcnt_d = rcnt_q;
    if (fill_done && rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
  end

  // Fill counter register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign READ_COUNT = rcnt_q;
`else
  logic unused_fill_done;
  assign unused_fill_done = fill_done;
`endif

endmodule

// File: tb/tb_instr_mem_block_responder.sv
// Bench for instr_mem_block_responder with READ_LATENCY=4 and image byte n = n[7:0].
module tb_instr_mem_block_responder;

  localparam int L = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         READ;
  logic [5:0]   ADDRESS;
  logic [127:0] READDATA;
  logic         BUSYWAIT;
`ifdef INSTMEM_READCNT_EN
  logic [15:0]  READ_COUNT;
`endif

  instr_mem_block_responder #(.READ_LATENCY(L)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .READ     (READ),
    .ADDRESS  (ADDRESS),
    .READDATA (READDATA),
    .BUSYWAIT (BUSYWAIT)
`ifdef INSTMEM_READCNT_EN
    ,
    .READ_COUNT (READ_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_data;
  int           exp_count;

  typedef struct {
    logic [5:0]   addr;
    int           abort_at;   // 0 = run to completion
    bit           hold;       // keep READ high into the next fill
    int           chg_at;     // cycle at which ADDRESS is disturbed (0 = never)
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[6];

  // Reference block contents from the image rule: byte n holds n mod 256.
  function automatic logic [127:0] blk_model(input logic [5:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = 8'((int'(a) * 16 + i) % 256);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
`ifdef INSTMEM_READCNT_EN
    chk(nm, 128'(READ_COUNT), 128'(exp_count));
`else
    if (nm.len() == 0) $display("empty check name");
`endif
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      chk("bw_idle", 128'(BUSYWAIT), 128'd0);
      chk("rd_idle", READDATA, exp_data);
    end
  endtask

  // One request: BUSYWAIT high for L cycles, low one cycle with data, or aborted.
  task automatic run_fill(input logic [5:0] a, input int abort_at, input bit hold,
                          input int chg_at, input logic [127:0] exp);
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = a; #1;
    chk("bw_req", 128'(BUSYWAIT), 128'd1);
    for (int c = 1; c < L; c++) begin
      @(posedge CLK); #1;
      if (c == chg_at) ADDRESS = ~a;
      if (c == abort_at) begin
        READ = 1'b0;
        @(posedge CLK); #1;
        chk("bw_abort", 128'(BUSYWAIT), 128'd0);
        chk("rd_abort", READDATA, exp_data);
        chk_cnt("cnt_abort");
        return;
      end
      #1;
      chk("bw_busy", 128'(BUSYWAIT), 128'd1);
    end
    @(posedge CLK); #1;
    exp_data = exp;
    if (exp_count != 65535) exp_count++;
    chk("bw_done", 128'(BUSYWAIT), 128'd0);
    chk("rd_done", READDATA, exp);
    chk_cnt("cnt_done");
    if (!hold) READ = 1'b0;
  endtask

  initial begin
    tbl[0] = '{6'd0,  0, 1'b0, 0, 128'h0F0E0D0C0B0A09080706050403020100};
    tbl[1] = '{6'd63, 0, 1'b0, 0, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};
    tbl[2] = '{6'd1,  0, 1'b0, 2, 128'h1F1E1D1C1B1A19181716151413121110};
    tbl[3] = '{6'd3,  2, 1'b0, 0, 128'h1F1E1D1C1B1A19181716151413121110};
    tbl[4] = '{6'd5,  0, 1'b1, 0, 128'h5F5E5D5C5B5A59585756555453525150};
    tbl[5] = '{6'd5,  0, 1'b0, 0, 128'h5F5E5D5C5B5A59585756555453525150};

    RESET = 1'b0; READ = 1'b0; ADDRESS = '0;
    exp_data = '0; exp_count = 0;
    #1;
    for (int i = 0; i < 1024; i++) dut.mem[i] = 8'(i);
    chk("rst_rd", READDATA, 128'd0);
    chk("rst_bw", 128'(BUSYWAIT), 128'd0);
    chk_cnt("rst_cnt");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    idle(1);

    // Directed table: basic, top block, address disturbance, abort, back-to-back.
    for (int v = 0; v < 6; v++) begin
      run_fill(tbl[v].addr, tbl[v].abort_at, tbl[v].hold, tbl[v].chg_at, tbl[v].exp);
      if (tbl[v].abort_at != 0) chk("rd_tbl_abort", READDATA, tbl[v].exp);
      if (!tbl[v].hold) idle(1);
    end

    // Reset in the middle of a fill.
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 6'd7;
    repeat (2) @(posedge CLK);
    #1;
    chk("bw_pre_rst", 128'(BUSYWAIT), 128'd1);
    READ = 1'b0; RESET = 1'b0; #1;
    exp_data = '0; exp_count = 0;
    chk("bw_async_rst", 128'(BUSYWAIT), 128'd0);
    chk("rd_async_rst", READDATA, 128'd0);
    chk_cnt("cnt_async_rst");
    @(posedge CLK); #1 RESET = 1'b1;
    run_fill(6'd0, 0, 1'b0, 0, 128'h0F0E0D0C0B0A09080706050403020100);
    idle(1);

    // Randomized traffic against the block/timing model.
    for (int t = 0; t < 40; t++) begin
      logic [5:0] a;
      int ab;
      bit hold;
      a    = 6'($urandom);
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L - 1)) : 0;
      hold = (ab == 0) && ($urandom_range(0, 1) == 1);
      run_fill(a, ab, hold, int'($urandom_range(0, L)), blk_model(a));
      if (!hold) idle(int'($urandom_range(0, 2)));
    end
    READ = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
